jtag_master: RTL and testbench
==============================

# jtag_master

- Initiator side of the virtual JTAG path: takes shift commands from the control logic and generates V_TCK/V_TMS/V_TDI for the downstream JTAG mux, capturing V_TDO.
- Each command is one of:
  - a TMS sequence, for TAP state navigation;
  - a data shift of 1–32 bits, LSB first, returning the captured TDO bits.
- Sits between the PCI-side register file and the 12-way target mux.

## Interface

Parameters:
- CLK_DIV, 4, TCK half-period in CLK cycles; legal range 1..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  high only in IDLE; command accepted on a CLK edge with CMD_VALID && CMD_READY.
- CMD_TYPE  in  1  0 = TMS sequence, 1 = data shift.
- CMD_LEN  in  5  bit count minus one (0 → 1 bit, 31 → 32 bits).
- CMD_DATA  in  32  bit i drives bit i of the sequence (on TMS if CMD_TYPE=0, on TDI if 1).
- CMD_EXIT  in  1  shift only: drive TMS=1 on the last bit.
- RSP_VALID  out  1  one-cycle pulse, command complete.
- RSP_DATA  out  32  captured TDO; bit i = TDO sampled on TCK rising edge i; bits above CMD_LEN are 0; held until next RSP_VALID.
- BUSY  out  1  high in any state except IDLE.
- V_TCK  out  1  JTAG clock.
- V_TMS  out  1  JTAG mode select.
- V_TDI  out  1  JTAG data to target.
- V_TDO  in  1  JTAG data from the selected target.

## Operation

- States: IDLE, LOW, HIGH, DONE (plus INIT when the configuration macro is defined).
- On accept:
  - latch CMD_TYPE, CMD_LEN, CMD_DATA, CMD_EXIT;
  - clear the bit index and RSP_DATA shift register;
  - go to LOW.
- LOW:
  - V_TCK=0.
  - V_TMS/V_TDI present bit[index] from the first cycle.
  - Lasts CLK_DIV cycles, then go to HIGH.
- HIGH:
  - V_TCK=1.
  - On the edge entering HIGH, capture V_TDO into RSP_DATA[index].
  - Lasts CLK_DIV cycles.
  - Then, if index == len, go to DONE; else increment index and go to LOW.
- DONE, one cycle:
  - RSP_VALID=1, V_TCK=0;
  - then go to IDLE.
- TMS sequence mode:
  - V_TMS = CMD_DATA[index];
  - V_TDI = 0;
  - captured TDO is still returned.
- Shift mode:
  - V_TDI = CMD_DATA[index];
  - V_TMS = 0, except V_TMS = CMD_EXIT on the last bit.
- Idle outputs:
  - V_TCK = 0.
  - V_TMS and V_TDI hold the last driven values, so the TAP state is preserved.
- CMD_VALID outside IDLE is ignored; no queueing.

## Timing

- Reset values:
  - V_TCK=0, V_TMS=1, V_TDI=0;
  - RSP_VALID=0, RSP_DATA=0, BUSY=0;
  - state IDLE (INIT if macro), so CMD_READY=1 the cycle after RST_N rises (0 if macro).
- Command of N bits accepted at edge 0:
  - V_TCK high intervals are cycles [2k·CLK_DIV+CLK_DIV+1, 2(k+1)·CLK_DIV] for k = 0..N-1;
  - RSP_VALID is at cycle 2·N·CLK_DIV+1;
  - CMD_READY returns at cycle 2·N·CLK_DIV+2.
- Back-to-back: a new command may be accepted on the edge where CMD_READY first returns high.
- TDI/TMS change only while V_TCK=0, giving CLK_DIV cycles of setup to the rising edge.
- Reset mid-command:
  - abort immediately with reset values;
  - no RSP_VALID.
- CLK_DIV=1: TCK = CLK/2; all rules above still hold.

## Configuration

- JTAG_MASTER_AUTO_RESET_EN defined:
  - after reset, the state machine enters INIT;
  - INIT clocks 5 TCK periods with V_TMS=1 and V_TDI=0, same timing as LOW/HIGH, forcing every target TAP to Test-Logic-Reset;
  - CMD_READY=0 and BUSY=1 during INIT;
  - then go to IDLE, with no RSP_VALID.
- Undefined: IDLE directly after reset.

## Test plan

- CLK_DIV=2, TMS command LEN=4 (5 bits), DATA=0x1F → five V_TCK pulses with V_TMS=1 on each; RSP_VALID at cycle 21; V_TDI stays 0.
- Shift LEN=7, DATA=0xA5, EXIT=1, V_TDO model returning 0x3C LSB first → V_TDI sequence 1,0,1,0,0,1,0,1; V_TMS=1 only on bit 7; RSP_DATA=0x0000003C.
- Shift LEN=31, DATA=0xDEADBEEF, V_TDO looped to V_TDI → RSP_DATA=0xDEADBEEF after 128+1 cycles (CLK_DIV=2).
- Two commands back-to-back with CMD_VALID held, plus CMD_VALID pulses while BUSY → exactly two RSP_VALID pulses; the second command starts the cycle CMD_READY reasserts; ignored pulses produce nothing.
- RST_N low during bit 3 of a 16-bit shift → next cycle V_TCK=0, V_TMS=1, BUSY=0, no RSP_VALID; a following 1-bit command completes normally.
- Macro defined → after reset, 5 TCK pulses with V_TMS=1, CMD_READY=0 throughout, then CMD_READY=1; macro undefined → CMD_READY=1 the cycle after reset.

Source files
------------

// File: rtl/jtag_master.sv
// jtag_master: virtual JTAG initiator; runs TMS sequences and 1-32 bit LSB-first data shifts.
// Optional macro JTAG_MASTER_AUTO_RESET_EN: clock 5 TCK periods with TMS=1 after reset.
module jtag_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_type_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    input  logic        cmd_exit_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        v_tck_o,
    output logic        v_tms_o,
    output logic        v_tdi_o,
    input  logic        v_tdo_i
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, DONE, INIT} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  next_idx;
    logic        type_q, type_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic        exit_q, exit_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] rsp_q, rsp_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
`ifdef JTAG_MASTER_AUTO_RESET_EN
    logic [2:0]  init_cnt_q, init_cnt_d;
    logic        init_hi_q, init_hi_d;
`endif

    // TMS/TDI are updated only on edges entering LOW, so they are stable through each HIGH phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        next_idx = idx_q + 5'd1;
        type_d   = type_q;
        len_d    = len_q;
        data_d   = data_q;
        exit_d   = exit_q;
        shift_d  = shift_q;
        rsp_d    = rsp_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
`ifdef JTAG_MASTER_AUTO_RESET_EN
        init_cnt_d = init_cnt_q;
        init_hi_d  = init_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    type_d  = cmd_type_i;
                    len_d   = cmd_len_i;
                    data_d  = cmd_data_i;
                    exit_d  = cmd_exit_i;
                    idx_d   = 5'd0;
                    shift_d = 32'd0;
                    cnt_d   = 8'd0;
                    state_d = LOW;
                    if (cmd_type_i) begin
                        tdi_d = cmd_data_i[0];
                        tms_d = cmd_exit_i && (cmd_len_i == 5'd0);
                    end else begin
                        tms_d = cmd_data_i[0];
                        tdi_d = 1'b0;
                    end
                end
            end
            LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = v_tdo_i;
                    state_d        = HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q == len_q) begin
                        rsp_d   = shift_q;
                        state_d = DONE;
                    end else begin
                        idx_d   = next_idx;
                        state_d = LOW;
                        if (type_q) begin
                            tdi_d = data_q[next_idx];
                            tms_d = exit_q && (next_idx == len_q);
                        end else begin
                            tms_d = data_q[next_idx];
                            tdi_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef JTAG_MASTER_AUTO_RESET_EN
            INIT: begin
                tms_d = 1'b1;
                tdi_d = 1'b0;
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = 8'd0;
                    init_hi_d = !init_hi_q;
                    if (init_hi_q) begin
                        if (init_cnt_q == 3'd4) begin
                            state_d = IDLE;
                        end else begin
                            init_cnt_d = init_cnt_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
`ifdef JTAG_MASTER_AUTO_RESET_EN
            state_q    <= INIT;
            init_cnt_q <= 3'd0;
            init_hi_q  <= 1'b0;
`else
            state_q    <= IDLE;
`endif
            cnt_q   <= 8'd0;
            idx_q   <= 5'd0;
            type_q  <= 1'b0;
            len_q   <= 5'd0;
            data_q  <= 32'd0;
            exit_q  <= 1'b0;
            shift_q <= 32'd0;
            rsp_q   <= 32'd0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
`ifdef JTAG_MASTER_AUTO_RESET_EN
            init_cnt_q <= init_cnt_d;
            init_hi_q  <= init_hi_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            len_q   <= len_d;
            data_q  <= data_d;
            exit_q  <= exit_d;
            shift_q <= shift_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign rsp_data_o  = rsp_q;
    assign v_tms_o     = tms_q;
    assign v_tdi_o     = tdi_q;
`ifdef JTAG_MASTER_AUTO_RESET_EN
    assign v_tck_o     = (state_q == HIGH) || ((state_q == INIT) && init_hi_q);
`else
    assign v_tck_o     = (state_q == HIGH);
`endif

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed commands with a response scoreboard for jtag_master (CLK_DIV=2).
// A TDO model answers either from a pattern register or by looping V_TDI back.
module tb_jtag_master;
    localparam int DIV = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        cmd_exit;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        v_tck;
    logic        v_tms;
    logic        v_tdi;
    logic        v_tdo;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rspCount = 0;

    logic [31:0] tdoPat = 32'd0;
    logic        loopMode = 1'b0;
    int          tdoBase = 0;
    int          riseCnt = 0;
    logic [4:0]  bitIdx;
    logic        prevTck = 1'b0;
    logic        riseTms = 1'b0;
    logic        riseTdi = 1'b0;
    logic [31:0] tmsBits = 32'd0;
    logic [31:0] tdiBits = 32'd0;
    int          holdViol = 0;

    jtag_master #(.CLK_DIV(DIV)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_type_i (cmd_type),
        .cmd_len_i  (cmd_len),
        .cmd_data_i (cmd_data),
        .cmd_exit_i (cmd_exit),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .busy_o     (busy),
        .v_tck_o    (v_tck),
        .v_tms_o    (v_tms),
        .v_tdi_o    (v_tdi),
        .v_tdo_i    (v_tdo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign bitIdx = 5'(riseCnt - tdoBase);
    assign v_tdo  = loopMode ? v_tdi : tdoPat[bitIdx];

    // Record TMS/TDI at every TCK rise and flag any change while TCK stays high.
    always @(negedge clk) begin
        prevTck <= v_tck;
        if (v_tck && !prevTck) begin
            riseCnt         <= riseCnt + 1;
            tmsBits[bitIdx] <= v_tms;
            tdiBits[bitIdx] <= v_tdi;
            riseTms         <= v_tms;
            riseTdi         <= v_tdi;
        end else if (v_tck && ((v_tms !== riseTms) || (v_tdi !== riseTdi))) begin
            holdViol <= holdViol + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rspCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic typ, input logic [4:0] len, input logic [31:0] data,
                                 input logic ex, input logic [31:0] pat, input logic loop,
                                 input bit expectRsp, input logic [31:0] expData,
                                 output int acceptCyc);
        int w;
        exp_t e;
        cmd_type  = typ;
        cmd_len   = len;
        cmd_data  = data;
        cmd_exit  = ex;
        tdoPat    = pat;
        loopMode  = loop;
        tdoBase   = riseCnt;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        cmd_valid = 1'b0;
        if (expectRsp) begin
            e.data = expData;
            e.cyc  = acceptCyc + 2 * (int'(len) + 1) * DIV;
            expQ.push_back(e);
        end
    endtask

    task automatic waitIdle();
        int w;
        w = 0;
        while ((expQ.size() != 0 || busy) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            checkOutput("idle_timeout", 32'd0, 32'd1);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        int rc0;
        int w;
        int initBase;
        int initViol;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 1'b0;
        cmd_len   = 5'd0;
        cmd_data  = 32'd0;
        cmd_exit  = 1'b0;
        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("rst_tck", 32'(v_tck), 32'd0);
        checkOutput("rst_tms", 32'(v_tms), 32'd1);
        checkOutput("rst_tdi", 32'(v_tdi), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        initBase = riseCnt;
        rst_n = 1'b1;
        @(negedge clk);
`ifdef JTAG_MASTER_AUTO_RESET_EN
        initViol = 0;
        w = 0;
        while (busy && w < 400) begin
            if (cmd_ready || !v_tms || v_tdi) initViol++;
            @(negedge clk);
            w++;
        end
        checkOutput("init_pulses", 32'(riseCnt - initBase), 32'd5);
        checkOutput("init_ready_low_tms_high", 32'(initViol), 32'd0);
        checkOutput("ready_after_init", 32'(cmd_ready), 32'd1);
`else
        initViol = 0;
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
        checkOutput("busy_after_reset", 32'(busy), 32'd0);
        checkOutput("no_init_pulses", 32'(riseCnt - initBase + initViol), 32'd0);
`endif

        // TMS sequence of 5 ones; TDO pattern bits above LEN must be dropped
        applyStimulus(1'b0, 5'd4, 32'h0000_001F, 1'b0, 32'hFFFF_FFEA, 1'b0, 1'b1, 32'h0000_000A, a);
        waitIdle();
        checkOutput("t1_pulses", 32'(riseCnt - tdoBase), 32'd5);
        checkOutput("t1_tms_seq", tmsBits & 32'h1F, 32'h1F);
        checkOutput("t1_tdi_seq", tdiBits & 32'h1F, 32'h00);
        repeat (3) @(negedge clk);
        checkOutput("t1_rsp_hold", rsp_data, 32'h0000_000A);

        // Shift 0xA5 with exit, TDO returns 0x3C
        applyStimulus(1'b1, 5'd7, 32'h0000_00A5, 1'b1, 32'h0000_003C, 1'b0, 1'b1, 32'h0000_003C, a);
        checkOutput("t2_rsp_held_at_accept", rsp_data, 32'h0000_000A);
        waitIdle();
        checkOutput("t2_pulses", 32'(riseCnt - tdoBase), 32'd8);
        checkOutput("t2_tdi_seq", tdiBits & 32'hFF, 32'hA5);
        checkOutput("t2_tms_seq", tmsBits & 32'hFF, 32'h80);
        checkOutput("t2_idle_tms_hold", 32'(v_tms), 32'd1);
        checkOutput("t2_idle_tck", 32'(v_tck), 32'd0);

        // Full 32-bit shift with TDO looped to TDI
        applyStimulus(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, a);
        waitIdle();
        checkOutput("t3_tdi_seq", tdiBits, 32'hDEAD_BEEF);
        checkOutput("t3_tms_seq", tmsBits, 32'h0000_0000);

        // Back-to-back with CMD_VALID held, then ignored pulses while busy
        rc0       = rspCount;
        cmd_type  = 1'b1;
        cmd_len   = 5'd2;
        cmd_data  = 32'h0000_0005;
        cmd_exit  = 1'b0;
        loopMode  = 1'b1;
        tdoBase   = riseCnt;
        cmd_valid = 1'b1;
        checkOutput("t4_ready_before_a", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a = cyc;
        expQ.push_back('{data: 32'h0000_0005, cyc: a + 2 * 3 * DIV});
        cmd_len  = 5'd7;
        cmd_data = 32'h0000_0096;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        b = cyc;
        checkOutput("t4_b_accept_cycle", 32'(b), 32'(a + 2 * 3 * DIV + 2));
        expQ.push_back('{data: 32'h0000_0096, cyc: b + 2 * 8 * DIV});
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        cmd_type  = 1'b0;
        cmd_len   = 5'd0;
        cmd_data  = 32'h0;
        cmd_valid = 1'b1;
        checkOutput("t4_busy_during_pulse", 32'(busy), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitIdle();
        repeat (10) @(negedge clk);
        checkOutput("t4_rsp_count", 32'(rspCount - rc0), 32'd2);

        // Reset during bit 3 of a 16-bit shift
        rc0 = rspCount;
        applyStimulus(1'b1, 5'd15, 32'h1234_ABCD, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, a);
        w = 0;
        while (!((riseCnt - tdoBase) == 3 && !v_tck) && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("t5_reached_bit3", 32'(riseCnt - tdoBase), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_tck", 32'(v_tck), 32'd0);
        checkOutput("t5_tms", 32'(v_tms), 32'd1);
        checkOutput("t5_tdi", 32'(v_tdi), 32'd0);
        checkOutput("t5_rsp_data", rsp_data, 32'd0);
        checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef JTAG_MASTER_AUTO_RESET_EN
        checkOutput("t5_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        waitIdle();
`else
        checkOutput("t5_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
`endif
        checkOutput("t5_no_rsp", 32'(rspCount - rc0), 32'd0);

        // Single-bit shift with exit after the abort
        applyStimulus(1'b1, 5'd0, 32'h0000_0001, 1'b1, 32'd0, 1'b1, 1'b1, 32'h0000_0001, a);
        waitIdle();
        checkOutput("t6_pulses", 32'(riseCnt - tdoBase), 32'd1);
        checkOutput("t6_tms_bit", tmsBits & 32'h1, 32'h1);
        checkOutput("t6_tdi_bit", tdiBits & 32'h1, 32'h1);

        repeat (10) @(negedge clk);
        checkOutput("tdi_tms_stable_high", 32'(holdViol), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
